uart_boot_loader: RTL

Wishbone master that loads a program image received as a byte stream from the UART receiver into instruction memory at power-up, holding the processor core in reset until the image is written and checksum-verified. Sits between the UART receive path and the Wishbone interconnect's IMEM slave port, upstream of the SoC's instruction memory and boot-ROM instruction selection. A bypass input releases the core immediately when IMEM is preloaded or the boot ROM is used.

---
 rtl/uart_boot_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// Boot loader: receives a framed program image over the UART byte stream,
// writes it to IMEM over Wishbone and releases the core once the checksum matches.
module uart_boot_loader #(
  parameter logic [31:0] IMEM_BASE   = 32'h0000_0000,
  parameter int          MAX_WORDS   = 128,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        bypass_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  output logic        core_reset_o,
  output logic        done_o,
  output logic [2:0]  err_code_o,
  output logic [15:0] words_loaded_o
);
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR} state_t;

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);
  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] idx;
  logic [15:0] timer;
  logic [1:0]  bcnt;
  logic [23:0] asm_word;
  logic [7:0]  csum;
  logic [7:0]  skid;
  logic        skid_full;
  logic        pvalid;
  logic [7:0]  pbyte;
  logic [15:0] len_rx;

  assign wbm_stb_o = wbm_cyc_o;
  assign wbm_we_o  = wbm_cyc_o;
  assign wbm_sel_o = wbm_cyc_o ? 4'hF : 4'h0;
  assign len_rx    = {pbyte, len_lo};

  // Byte to consume this cycle: nothing while a write is in flight, skid first otherwise.
  always_comb begin
    pvalid = 1'b0;
    pbyte  = rx_data_i;
    if (!wbm_cyc_o) begin
      if (skid_full) begin
        pvalid = 1'b1;
        pbyte  = skid;
      end else begin
        pvalid = rx_valid_i;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state          <= IDLE;
      wbm_adr_o      <= 32'h0;
      wbm_dat_o      <= 32'h0;
      wbm_cyc_o      <= 1'b0;
      core_reset_o   <= 1'b1;
      done_o         <= 1'b0;
      err_code_o     <= 3'd0;
      words_loaded_o <= 16'd0;
      len_lo         <= 8'd0;
      len            <= 16'd0;
      idx            <= 16'd0;
      timer          <= 16'd0;
      bcnt           <= 2'd0;
      asm_word       <= 24'd0;
      csum           <= 8'd0;
      skid           <= 8'd0;
      skid_full      <= 1'b0;
    end else begin
      if (state == DATA || state == CSUM) begin
        if (wbm_cyc_o) begin
          if (rx_valid_i && !skid_full) begin
            skid      <= rx_data_i;
            skid_full <= 1'b1;
          end
        end else if (skid_full) begin
          skid      <= rx_data_i;
          skid_full <= rx_valid_i;
        end
      end

      if (wbm_cyc_o) begin
        if (wbm_ack_i) begin
          wbm_cyc_o      <= 1'b0;
          timer          <= 16'd0;
          words_loaded_o <= words_loaded_o + 16'd1;
        end else begin
          timer <= timer + 16'd1;
        end
      end

      case (state)
        IDLE: begin
          if (bypass_i) begin
            state        <= DONE;
            done_o       <= 1'b1;
            core_reset_o <= 1'b0;
          end else if (pvalid && pbyte == 8'hA5) begin
            state <= LEN0;
          end
        end
        LEN0: if (pvalid) begin
          len_lo <= pbyte;
          state  <= LEN1;
        end
        LEN1: if (pvalid) begin
          if (len_rx == 16'd0 || len_rx > MAX_LEN) begin
            state      <= ERROR;
            err_code_o <= 3'd1;
          end else begin
            len   <= len_rx;
            idx   <= 16'd0;
            bcnt  <= 2'd0;
            csum  <= 8'd0;
            state <= DATA;
          end
        end
        DATA: if (pvalid) begin
          csum     <= csum + pbyte;
          bcnt     <= bcnt + 2'd1;
          asm_word <= {pbyte, asm_word[23:8]};
          if (bcnt == 2'd3) begin
            wbm_adr_o <= IMEM_BASE + {14'b0, idx, 2'b00};
            wbm_dat_o <= {pbyte, asm_word};
            wbm_cyc_o <= 1'b1;
            timer     <= 16'd0;
            idx       <= idx + 16'd1;
            if (idx + 16'd1 == len) state <= CSUM;
          end
        end
        CSUM: if (pvalid) begin
          if (pbyte == csum) begin
            state        <= DONE;
            done_o       <= 1'b1;
            core_reset_o <= 1'b0;
          end else begin
            state      <= ERROR;
            err_code_o <= 3'd2;
          end
        end
        default: ;
      endcase

      // Bus-side faults override the byte path and abandon the cycle at once.
      if (wbm_cyc_o && !wbm_ack_i && timer == TO_LAST) begin
        state      <= ERROR;
        err_code_o <= 3'd4;
        wbm_cyc_o  <= 1'b0;
      end else if (wbm_cyc_o && rx_valid_i && skid_full) begin
        state      <= ERROR;
        err_code_o <= 3'd3;
        wbm_cyc_o  <= 1'b0;
      end
    end
  end
endmodule
